// File: rtl/bch80_64_pkg.sv
// Shared definitions for the (80,64) systematic code: widths, parity-row
// table (also used by the encoder), decoder state type and syndrome function.
package bch80_64_pkg;

  localparam int unsigned CW_W   = 80;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned PAR_W  = 16;

  // Bits [15:10] carry the column index so rows are distinct; the low 3 set
  // bits keep every row at weight >= 2 so no row aliases a parity-bit error.
  localparam logic [PAR_W-1:0] P_ROWS [DATA_W] = '{
    16'h0007, 16'h0407, 16'h0807, 16'h0C07, 16'h1007, 16'h1407, 16'h1807, 16'h1C07,
    16'h2007, 16'h2407, 16'h2807, 16'h2C07, 16'h3007, 16'h3407, 16'h3807, 16'h3C07,
    16'h4007, 16'h4407, 16'h4807, 16'h4C07, 16'h5007, 16'h5407, 16'h5807, 16'h5C07,
    16'h6007, 16'h6407, 16'h6807, 16'h6C07, 16'h7007, 16'h7407, 16'h7807, 16'h7C07,
    16'h8007, 16'h8407, 16'h8807, 16'h8C07, 16'h9007, 16'h9407, 16'h9807, 16'h9C07,
    16'hA007, 16'hA407, 16'hA807, 16'hAC07, 16'hB007, 16'hB407, 16'hB807, 16'hBC07,
    16'hC007, 16'hC407, 16'hC807, 16'hCC07, 16'hD007, 16'hD407, 16'hD807, 16'hDC07,
    16'hE007, 16'hE407, 16'hE807, 16'hEC07, 16'hF007, 16'hF407, 16'hF807, 16'hFC07
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYND,
    ST_SEARCH,
    ST_OUT
  } state_e;

  function automatic logic [PAR_W-1:0] syndrome(input logic [CW_W-1:0] cw);
    logic [PAR_W-1:0] s;
    s = cw[PAR_W-1:0];
    for (int unsigned j = 0; j < DATA_W; j++) begin
      if (cw[7'(CW_W-1-j)]) s ^= P_ROWS[6'(j)];
    end
    return s;
  endfunction

endpackage

// File: rtl/bch80_64_syn.sv
// Combinational syndrome generator; with a zero parity field it yields the
// encoder's parity bits.
import bch80_64_pkg::*;

module bch80_64_syn (
  input  logic [CW_W-1:0]  cw,
  output logic [PAR_W-1:0] syn
);

  always_comb syn = syndrome(cw);

endmodule

// File: rtl/bch80_64_dec.sv
// (80,64) single-error-correcting decoder with sequential column search.
// Optional saturating error counters when BCH80_64_DEC_ERR_CNT_EN is defined.
import bch80_64_pkg::*;

module bch80_64_dec #(
  parameter int unsigned LANES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW_W-1:0]  in_cw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic             out_corr,
  output logic             out_uncorr,
  output logic [6:0]       out_err_pos
`ifdef BCH80_64_DEC_ERR_CNT_EN
  ,
  output logic [15:0]      cnt_corr,
  output logic [15:0]      cnt_uncorr
`endif
);

  state_e            state_q, state_d;
  logic              rdy_q, rdy_d;
  logic [CW_W-1:0]   cw_q, cw_d;
  logic [PAR_W-1:0]  syn_q, syn_d;
  logic [5:0]        idx_q, idx_d;
  logic              corr_q, corr_d;
  logic              uncorr_q, uncorr_d;
  logic [6:0]        pos_q, pos_d;

  logic [PAR_W-1:0]  syn_w;
  logic              found;
  logic [5:0]        jj;
  logic [5:0]        jsel;
  logic [6:0]        kpos;
  logic [6:0]        fpos;
  logic              last;

  bch80_64_syn u_syn (
    .cw  (cw_q),
    .syn (syn_w)
  );

  always_comb begin
    state_d  = state_q;
    cw_d     = cw_q;
    syn_d    = syn_q;
    idx_d    = idx_q;
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    pos_d    = pos_q;
    found    = 1'b0;
    jj       = '0;
    jsel     = '0;
    kpos     = '0;
    fpos     = '0;
    last     = ({1'b0, idx_q} + 7'(LANES)) == 7'(DATA_W);

    case (state_q)
      ST_IDLE: begin
        if (in_valid && rdy_q) begin
          cw_d     = in_cw;
          corr_d   = 1'b0;
          uncorr_d = 1'b0;
          pos_d    = '0;
          state_d  = ST_SYND;
        end
      end
      ST_SYND: begin
        syn_d = syn_w;
        if (syn_w == '0) begin
          state_d = ST_OUT;
        end else if ((syn_w & (syn_w - PAR_W'(1))) == '0) begin
          // One-hot syndrome: the error sits in the parity field at that bit.
          for (int unsigned b = 0; b < PAR_W; b++) begin
            if (syn_w[4'(b)]) kpos = 7'(b);
          end
          cw_d[kpos] = ~cw_q[kpos];
          corr_d     = 1'b1;
          pos_d      = kpos;
          state_d    = ST_OUT;
        end else begin
          idx_d   = '0;
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        for (int unsigned i = 0; i < LANES; i++) begin
          jj = idx_q + 6'(i);
          if (!found && syn_q == P_ROWS[jj]) begin
            found = 1'b1;
            jsel  = jj;
          end
        end
        if (found) begin
          fpos       = 7'(CW_W-1) - {1'b0, jsel};
          cw_d[fpos] = ~cw_q[fpos];
          corr_d     = 1'b1;
          pos_d      = fpos;
          state_d    = ST_OUT;
        end else if (last) begin
          uncorr_d = 1'b1;
          state_d  = ST_OUT;
        end else begin
          idx_d = idx_q + 6'(LANES);
        end
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rdy_q    <= 1'b0;
      cw_q     <= '0;
      syn_q    <= '0;
      idx_q    <= '0;
      corr_q   <= 1'b0;
      uncorr_q <= 1'b0;
      pos_q    <= '0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      cw_q     <= cw_d;
      syn_q    <= syn_d;
      idx_q    <= idx_d;
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
      pos_q    <= pos_d;
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = (state_q == ST_OUT);
  assign out_data    = cw_q[CW_W-1:PAR_W];
  assign out_corr    = corr_q;
  assign out_uncorr  = uncorr_q;
  assign out_err_pos = pos_q;

`ifdef BCH80_64_DEC_ERR_CNT_EN
  logic [15:0] cnt_corr_q, cnt_corr_d;
  logic [15:0] cnt_uncorr_q, cnt_uncorr_d;

  always_comb begin
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;
    if (state_q == ST_OUT && out_ready) begin
      if (corr_q && cnt_corr_q != '1)     cnt_corr_d   = cnt_corr_q + 16'd1;
      if (uncorr_q && cnt_uncorr_q != '1) cnt_uncorr_d = cnt_uncorr_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  assign cnt_corr   = cnt_corr_q;
  assign cnt_uncorr = cnt_uncorr_q;
`endif

endmodule

// File: tb/tb_bch80_64_dec.sv
// Scoreboard bench for bch80_64_dec: directed and random codewords checked
// against a behavioural decode model, with latency and handshake checks.
module tb_bch80_64_dec;
  import bch80_64_pkg::*;

  localparam int unsigned LANES = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [79:0] in_cw = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic        out_corr;
  logic        out_uncorr;
  logic [6:0]  out_err_pos;
`ifdef BCH80_64_DEC_ERR_CNT_EN
  logic [15:0] cnt_corr;
  logic [15:0] cnt_uncorr;
`endif

  bch80_64_dec #(.LANES(LANES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cw       (in_cw),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_corr    (out_corr),
    .out_uncorr  (out_uncorr),
    .out_err_pos (out_err_pos)
`ifdef BCH80_64_DEC_ERR_CNT_EN
    ,
    .cnt_corr    (cnt_corr),
    .cnt_uncorr  (cnt_uncorr)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [63:0] data;
    logic        corr;
    logic        uncorr;
    logic [6:0]  pos;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   last_xfer = -100;
  bit   rnd_bp = 0;
  int   mdl_cc = 0;
  int   mdl_cu = 0;

  function automatic void chk(string name, logic [79:0] act, logic [79:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Parity the encoder would attach to this data word.
  function automatic logic [15:0] parity_of(logic [63:0] d);
    logic [15:0] p = '0;
    for (int j = 0; j < 64; j++) begin
      if (d[6'(63 - j)]) p ^= P_ROWS[6'(j)];
    end
    return p;
  endfunction

  function automatic logic [79:0] encode(logic [63:0] d);
    return {d, parity_of(d)};
  endfunction

  // Decode outcome: recompute parity of received data, compare with received
  // parity, then classify the difference.
  function automatic exp_t model(logic [79:0] cw);
    exp_t        e;
    logic [15:0] s;
    logic [79:0] fixed;
    int          hit;
    fixed = cw;
    hit = -1;
    s = cw[15:0] ^ parity_of(cw[79:16]);
    e.corr = 1'b0;
    e.uncorr = 1'b0;
    e.pos = '0;
    e.lat = 2;
    e.acc = 0;
    if (s != 16'h0) begin
      if ($countones(s) == 1) begin
        e.corr = 1'b1;
        e.pos = 7'($clog2(s));
      end else begin
        for (int j = 0; j < 64; j++) begin
          if (hit < 0 && P_ROWS[6'(j)] == s) hit = j;
        end
        if (hit >= 0) begin
          e.corr = 1'b1;
          e.pos = 7'(79 - hit);
          fixed[7'(79 - hit)] = ~fixed[7'(79 - hit)];
          e.lat = 2 + (hit + LANES) / LANES;
        end else begin
          e.uncorr = 1'b1;
          e.lat = 2 + 64 / LANES;
        end
      end
    end
    e.data = fixed[79:16];
    return e;
  endfunction

  // Monitor / scoreboard
  exp_t        mon_e;
  bit          vld_seen = 0;
  logic [72:0] snap;
  logic [72:0] cur;

  always @(negedge clk) begin
    cur = {out_data, out_corr, out_uncorr, out_err_pos};
    if (!rst_n) begin
      vld_seen = 0;
    end else if (out_valid) begin
      chk("in_ready_low_while_out", in_ready, 0);
      if (!vld_seen) begin
        vld_seen = 1;
        snap = cur;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got data %0h with no word pending (cycle %0d)", out_data, cyc);
        end else begin
          chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
        end
      end else begin
        chk("hold_stable", cur, snap);
      end
      if (out_ready) begin
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("out_data", out_data, mon_e.data);
          chk("out_corr", out_corr, mon_e.corr);
          chk("out_uncorr", out_uncorr, mon_e.uncorr);
          chk("out_err_pos", out_err_pos, mon_e.pos);
          if (mon_e.corr) mdl_cc++;
          if (mon_e.uncorr) mdl_cu++;
        end
        vld_seen = 0;
        last_xfer = cyc;
      end
    end else if (vld_seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL valid_dropped: out_valid fell without out_ready (cycle %0d)", cyc);
      vld_seen = 0;
    end
  end

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [79:0] cw, output int acc);
    exp_t e;
    int   k;
    k = 0;
    e = model(cw);
    in_cw = cw;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", k);
      acc = -1;
    end else begin
      e.acc = cyc;
      acc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 600) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0 || out_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d words still pending", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  logic [79:0] base;
  logic [79:0] cw;
  int          acc;
  int          nflip;
  int          k;

  initial begin
    #2;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_flags", {out_corr, out_uncorr, out_err_pos}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", in_ready, 1);

    base = encode(64'h0123_4567_89AB_CDEF);
    send(base, acc);                                    wait_idle();
    send(base ^ (80'd1 << 79), acc);                    wait_idle();
    send(base ^ (80'd1 << 16), acc);                    wait_idle();
    send(base ^ 80'd1, acc);                            wait_idle();
    send(base ^ (80'd1 << 79) ^ (80'd1 << 76), acc);    wait_idle();

    rnd_bp = 1;
    for (int n = 0; n < 40; n++) begin
      cw = encode({$urandom, $urandom});
      nflip = $urandom_range(0, 2);
      for (int f = 0; f < nflip; f++) begin
        k = $urandom_range(0, 79);
        cw[7'(k)] = ~cw[7'(k)];
      end
      send(cw, acc);
    end
    wait_idle();
    rnd_bp = 0;
    @(posedge clk);
    #2 out_ready = 1'b1;

    // Backpressure: hold the result, then check back-to-back acceptance.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(base ^ (80'd1 << 78), acc);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (10) @(negedge clk);
    chk("bp_out_valid_held", out_valid, 1);
    chk("bp_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(base, acc);
    chk("accept_after_transfer", acc - last_xfer, 1);
    wait_idle();

    // Reset during the fifth search cycle of a j=63 correction.
    send(base ^ (80'd1 << 16), acc);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    mdl_cc = 0;
    mdl_cu = 0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 0);
    chk("rst_mid_out_data", out_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst_release", in_ready, 1);
    repeat (25) @(posedge clk);
    #1;
    chk("no_stale_output", out_valid, 0);
    send(base, acc);
    wait_idle();

`ifdef BCH80_64_DEC_ERR_CNT_EN
    send(base ^ (80'd1 << 70), acc);                    wait_idle();
    send(base ^ (80'd1 << 5), acc);                     wait_idle();
    send(base ^ (80'd1 << 40), acc);                    wait_idle();
    send(base ^ (80'd1 << 79) ^ (80'd1 << 76), acc);    wait_idle();
    chk("cnt_corr", cnt_corr, 16'(mdl_cc));
    chk("cnt_uncorr", cnt_uncorr, 16'(mdl_cu));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bch80_64_dec.md
Name: bch80_64_dec

Overview:
- Downstream consumer of the (80,64) systematic encoder output.
- Accepts an 80-bit received codeword over a valid/ready handshake and computes the 16-bit syndrome.
- Corrects any single-bit error (data or parity) by a sequential column search, flags uncorrectable words, and returns the 64-bit data with a valid/ready handshake.
- Sits between the channel/storage read path and the data consumer.

Parameters:
- LANES, 4, parity-matrix columns compared per search cycle. Legal values: 1, 2, 4, 8, 16; must divide 64.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  codeword present
- in_ready  out  1  decoder can accept a codeword
- in_cw  in  80  received codeword: [79:16] data (bit 79-j = data bit 63-j), [15:0] parity
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  64  corrected data
- out_corr  out  1  single-bit error was corrected
- out_uncorr  out  1  nonzero syndrome with no matching column; out_data is the raw data
- out_err_pos  out  7  corrected codeword bit index (0..79); 0 when out_corr=0

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE.
  - in_ready=0 while rst_n is low; in_ready=1 on the first cycle after deassertion.
  - out_valid=0; out_data=0, out_corr=0, out_uncorr=0, out_err_pos=0.
  - Reset mid-search or mid-output abandons the word; nothing is emitted.
- Syndrome definition:
  - S = cw[15:0] XOR (XOR over j=0..63 of cw[79-j] ? P[j] : 0).
  - P[j] is the 16-bit parity row for data index j, from the package.
  - Arithmetic is GF(2) throughout.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, register in_cw and go to SYND.
  - SYND (1 cycle): compute S and register it.
    - S==0: go to OUT, corr=0, uncorr=0.
    - S one-hot at bit k: flip cw[k], go to OUT, corr=1, err_pos=k.
    - Otherwise: idx=0, go to SEARCH.
  - SEARCH: each cycle compare S against P[idx..idx+LANES-1].
    - Lowest matching j wins: flip cw[79-j], corr=1, err_pos=79-j, go to OUT.
    - If none match and idx+LANES==64: uncorr=1, go to OUT.
    - Else idx+=LANES.
  - OUT: out_valid=1 and outputs stable. On out_ready, go to IDLE and drop out_valid the next cycle.
- Handshake rules:
  - in_ready=1 only in IDLE; in_valid outside IDLE is ignored (held by the producer).
  - out_valid never drops without out_ready.
  - Outputs must not change while out_valid=1 and out_ready=0.
- Latency from accept to out_valid:
  - 2 cycles for a clean word or a parity-bit error.
  - 2+ceil((j+1)/LANES) cycles for a data error at index j.
  - 2+64/LANES cycles for an uncorrectable word.
- Throughput: one word per (latency+1) cycles minimum; no overlap.
- Duplicate columns: any duplicate P rows are resolved by the lowest index.

Optional Feature:
- Macro: BCH80_64_DEC_ERR_CNT_EN.
- When defined, adds ports cnt_corr (out, 16) and cnt_uncorr (out, 16):
  - Saturating counters, incremented on the OUT→IDLE transfer of a corrected or uncorrectable word respectively.
  - Cleared by rst_n.
  - Held at 16'hFFFF once saturated.
- When undefined, neither the ports nor the logic exist.

Decomposition:
- Package bch80_64_pkg holds:
  - CW_W=80, DATA_W=64, PAR_W=16.
  - Constant array of 64 parity rows P[0:63], shared with the encoder so both use one table.
  - State enum type.
  - Function computing the syndrome from an 80-bit word.
- One sub-module, bch80_64_syn: purely combinational syndrome generator (80 in, 16 out), reusable by the encoder for parity generation.

Test Plan:
- Clean word: encode data 64'h0123_4567_89AB_CDEF with a golden model and send it → out_valid 2 cycles after accept; out_data=0123456789ABCDEF; corr=0, uncorr=0.
- Data error: same word with bit 79 flipped (j=0) → corrected, err_pos=79. With bit 16 flipped (j=63), LANES=4 → corrected, err_pos=16, latency 18 cycles.
- Parity error: flip bit 0 → S=16'h0001; corrected; err_pos=0; latency 2.
- Uncorrectable: two-bit flip whose syndrome the golden model confirms matches no column → uncorr=1, out_data=raw data, latency 18 (LANES=4).
- Backpressure: hold out_ready=0 for 10 cycles → out_valid and outputs stable, in_ready=0. Release → next word accepted the cycle after transfer.
- Reset mid-SEARCH: assert rst_n low during cycle 5 of a search → out_valid=0 immediately. After release, no stale result appears and a new clean word decodes normally.
- With BCH80_64_DEC_ERR_CNT_EN defined: run 3 corrected and 1 uncorrectable words → cnt_corr=3, cnt_uncorr=1.
